// File: rtl/muxn_reg_if.sv
// muxn_reg_if: bus between the channel producers/consumer and muxn_reg.
// The producer-side signals are in_*, sel and rr_mode. The consumer-side
// signals are out_*. The slave modport is the mux's view of the bus.
interface muxn_reg_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      rr_mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, sel, rr_mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, sel, rr_mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/muxn_reg.sv
// muxn_reg: registered N-channel mux with valid/ready on every channel and
// a one-entry output register.
// Optional feature macro MUXN_RR_EN: when it is defined, the rotating-priority
// round-robin select is compiled in and rr_mode chooses it. Otherwise rr_mode
// is ignored and selection is always explicit (sel).
module muxn_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  muxn_reg_if.slave   bus
);

  if (CHANNELS < 2 || CHANNELS > 16 || (1 << SEL_W) < CHANNELS) begin : g_param_check
    $error("muxn_reg: CHANNELS must be 2..16 and fit in SEL_W bits");
  end

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  logic             valid_q;

  logic             load_ok;
  logic             hit;
  logic [SEL_W-1:0] chan_c;
  logic [WIDTH-1:0] chosen_data;
  logic             chosen_valid;
  logic             xfer;

  // The slot can take a word when it is empty or is being drained this cycle.
  assign load_ok = !valid_q || bus.out_ready;

`ifdef MUXN_RR_EN
  logic [SEL_W-1:0] ptr;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_chan;

  // Rotating priority: pick the valid channel at the smallest forward
  // distance from ptr. This is the same as scanning ptr, ptr+1, ... with
  // wrap, but it is written as a min-distance search so that no wrapped
  // index is needed.
  always_comb begin
    int unsigned p;
    int unsigned d;
    int unsigned best_d;
    rr_hit  = 1'b0;
    rr_chan = '0;
    p       = 32'(ptr);
    d       = 0;
    best_d  = CHANNELS;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      d = (i >= p) ? (i - p) : (i + CHANNELS - p);
      if (bus.in_valid[i] && d < best_d) begin
        best_d  = d;
        rr_hit  = 1'b1;
        rr_chan = SEL_W'(i);
      end
    end
  end

  // Channel choice: the explicit select, or the round-robin winner.
  always_comb begin
    hit    = 32'(bus.sel) < CHANNELS;
    chan_c = bus.sel;
    if (bus.rr_mode) begin
      hit    = rr_hit;
      chan_c = rr_chan;
    end
  end

  // Round-robin pointer: moves past the winner only on round-robin transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && bus.rr_mode) begin
      ptr <= (chan_c == SEL_W'(CHANNELS - 1)) ? '0 : chan_c + SEL_W'(1);
    end
  end
`else
  // Channel choice: always the explicit select. An out-of-range sel picks nothing.
  always_comb begin
    hit    = 32'(bus.sel) < CHANNELS;
    chan_c = bus.sel;
  end
`endif

  // Data/valid mux and the one-hot ready. Ready is forced low during reset.
  always_comb begin
    chosen_data  = '0;
    chosen_valid = 1'b0;
    bus.in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (hit && chan_c == SEL_W'(i)) begin
        chosen_data     = bus.in_data[i*WIDTH +: WIDTH];
        chosen_valid    = bus.in_valid[i];
        bus.in_ready[i] = load_ok && rst_n;
      end
    end
  end

  assign xfer = chosen_valid && load_ok;

  // Output register: a load overrides a drain, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= chosen_data;
      chan_q  <= chan_c;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_muxn_reg.sv
// tb_muxn_reg: self-checking bench for muxn_reg. It has an 8-channel
// instance with a behavioural model and a 6-channel instance for the
// out-of-range select case. Round-robin scenarios build only with MUXN_RR_EN.
module tb_muxn_reg;
  localparam int W  = 32;
  localparam int C8 = 8;
  localparam int C6 = 6;
  localparam int S  = 3;
`ifdef MUXN_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muxn_reg_if #(.WIDTH(W), .CHANNELS(C8), .SEL_W(S)) b8();
  muxn_reg_if #(.WIDTH(W), .CHANNELS(C6), .SEL_W(S)) b6();

  muxn_reg #(.WIDTH(W), .CHANNELS(C8), .SEL_W(S)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  muxn_reg #(.WIDTH(W), .CHANNELS(C6), .SEL_W(S)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference model of the 8-channel instance
  bit         m_v;
  logic [W-1:0] m_d;
  int         m_c;
  int         m_ptr;

  function automatic void model_reset();
    m_v = 0; m_d = '0; m_c = 0; m_ptr = 0;
  endfunction

  // Channel chosen under the current inputs, or -1 if there is none
  function automatic int choose8();
    if (RR_EN && b8.rr_mode) begin
      for (int k = 0; k < C8; k++) begin
        int ch = (m_ptr + k) % C8;
        if (b8.in_valid[ch]) return ch;
      end
      return -1;
    end
    return (int'(b8.sel) < C8) ? int'(b8.sel) : -1;
  endfunction

  function automatic logic [C8-1:0] exp_ready8();
    int c = choose8();
    logic [C8-1:0] r = '0;
    if (rst_n && c >= 0 && (!m_v || b8.out_ready)) r[c] = 1'b1;
    return r;
  endfunction

  task automatic set_data8(input int ch, input logic [W-1:0] v);
    b8.in_data[ch*W +: W] = v;
  endtask

  // Advance one clock and update the model. Ends 1 time unit after the edge.
  task automatic advance8();
    int c = choose8();
    bit rr = RR_EN && b8.rr_mode;
    bit x = rst_n && c >= 0 && (!m_v || b8.out_ready) && b8.in_valid[c];
    logic [W-1:0] d = (c >= 0) ? b8.in_data[c*W +: W] : '0;
    bit ordy = b8.out_ready;
    @(posedge clk);
    if (x) begin
      m_v = 1; m_d = d; m_c = c;
      if (rr) m_ptr = (c + 1) % C8;
    end else if (ordy) begin
      m_v = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    b8.in_data = '0; b8.in_valid = 8'hFF; b8.sel = 3'd7; b8.rr_mode = 1'b0; b8.out_ready = 1'b1;
    b6.in_data = '0; b6.in_valid = 6'h3F; b6.sel = 3'd0; b6.rr_mode = 1'b0; b6.out_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (b8.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", b8.out_valid); else n_pass++;
    n_chk++; if (b8.out_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", b8.out_data); else n_pass++;
    n_chk++; if (b8.out_chan !== 3'd0) $display("FAIL reset_chan got=%0d exp=0", b8.out_chan); else n_pass++;
    n_chk++; if (b8.in_ready !== 8'h00) $display("FAIL reset_ready got=%h exp=00", b8.in_ready); else n_pass++;
    n_chk++; if (b6.in_ready !== 6'h00) $display("FAIL reset_ready6 got=%h exp=00", b6.in_ready); else n_pass++;
    b8.in_valid = '0; b6.in_valid = '0;
    rst_n = 1'b1;
    advance8();
    n_chk++; if (b8.out_valid !== 1'b0 || b8.out_data !== 32'h0 || b8.out_chan !== 3'd0)
      $display("FAIL post_reset_idle got=%b/%h/%0d exp=0/0/0", b8.out_valid, b8.out_data, b8.out_chan);
    else n_pass++;
  endtask

  task automatic test_explicit();
    b8.rr_mode = 1'b0; b8.sel = 3'd7; b8.in_valid = 8'h80; b8.out_ready = 1'b1;
    set_data8(7, 32'hDEADBEEF);
    #1;
    n_chk++; if (b8.in_ready !== 8'h80) $display("FAIL explicit_ready got=%h exp=80", b8.in_ready); else n_pass++;
    advance8();
    b8.in_valid = '0;
    n_chk++; if (b8.out_valid !== 1'b1) $display("FAIL explicit_valid got=%b exp=1", b8.out_valid); else n_pass++;
    n_chk++; if (b8.out_data !== 32'hDEADBEEF) $display("FAIL explicit_data got=%h exp=deadbeef", b8.out_data); else n_pass++;
    n_chk++; if (b8.out_chan !== 3'd7) $display("FAIL explicit_chan got=%0d exp=7", b8.out_chan); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] v2 = $urandom;
    b8.out_ready = 1'b0; b8.sel = 3'd2; b8.in_valid = 8'h04;
    set_data8(2, v2);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (b8.in_ready !== 8'h00) $display("FAIL stall_ready got=%h exp=00 cyc=%0d", b8.in_ready, k); else n_pass++;
      advance8();
      n_chk++; if (b8.out_data !== 32'hDEADBEEF || b8.out_valid !== 1'b1)
        $display("FAIL stall_hold got=%b/%h exp=1/deadbeef cyc=%0d", b8.out_valid, b8.out_data, k);
      else n_pass++;
    end
    b8.out_ready = 1'b1;
    #1;
    n_chk++; if (b8.in_ready !== 8'h04) $display("FAIL release_ready got=%h exp=04", b8.in_ready); else n_pass++;
    advance8();
    b8.in_valid = '0;
    n_chk++; if (b8.out_valid !== 1'b1 || b8.out_data !== v2 || b8.out_chan !== 3'd2)
      $display("FAIL release_word got=%b/%h/%0d exp=1/%h/2", b8.out_valid, b8.out_data, b8.out_chan, v2);
    else n_pass++;
    advance8();
    n_chk++; if (b8.out_valid !== 1'b0) $display("FAIL drain_valid got=%b exp=0", b8.out_valid); else n_pass++;
  endtask

  task automatic test_out_of_range();
    b6.sel = 3'd6; b6.in_valid = 6'h3F; b6.out_ready = 1'b1;
    for (int i = 0; i < C6; i++) b6.in_data[i*W +: W] = 32'hA0000000 + i;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (b6.in_ready !== 6'h00) $display("FAIL oor_ready got=%h exp=00 cyc=%0d", b6.in_ready, k); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (b6.out_valid !== 1'b0) $display("FAIL oor_valid got=%b exp=0 cyc=%0d", b6.out_valid, k); else n_pass++;
    end
    b6.sel = 3'd5;
    #1;
    n_chk++; if (b6.in_ready !== 6'h20) $display("FAIL top_chan_ready got=%h exp=20", b6.in_ready); else n_pass++;
    @(posedge clk); #1;
    b6.in_valid = '0;
    n_chk++; if (b6.out_valid !== 1'b1 || b6.out_chan !== 3'd5 || b6.out_data !== 32'hA0000005)
      $display("FAIL top_chan_word got=%b/%0d/%h exp=1/5/a0000005", b6.out_valid, b6.out_chan, b6.out_data);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    b8.rr_mode = 1'b0; b8.sel = 3'd4; b8.in_valid = 8'h10; b8.out_ready = 1'b1;
    set_data8(4, 32'h12345678);
    advance8();
    n_chk++; if (b8.out_valid !== 1'b1) $display("FAIL pre_reset_load got=%b exp=1", b8.out_valid); else n_pass++;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++; if (b8.out_valid !== 1'b0 || b8.out_data !== 32'h0)
      $display("FAIL async_reset got=%b/%h exp=0/0", b8.out_valid, b8.out_data);
    else n_pass++;
    n_chk++; if (b8.in_ready !== 8'h00) $display("FAIL async_reset_ready got=%h exp=00", b8.in_ready); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_chk++; if (b8.in_ready !== 8'h10) $display("FAIL post_release_ready got=%h exp=10", b8.in_ready); else n_pass++;
    advance8();
    b8.in_valid = '0;
    n_chk++; if (b8.out_valid !== 1'b1 || b8.out_chan !== 3'd4)
      $display("FAIL first_accept got=%b/%0d exp=1/4", b8.out_valid, b8.out_chan);
    else n_pass++;
  endtask

`ifdef MUXN_RR_EN
  task automatic test_rr_sweep();
    do_reset();
    b8.rr_mode = 1'b1; b8.in_valid = 8'hFF; b8.out_ready = 1'b1;
    for (int i = 0; i < C8; i++) set_data8(i, 32'hC0DE0000 + i);
    for (int k = 0; k < 9; k++) begin
      advance8();
      n_chk++; if (b8.out_valid !== 1'b1 || int'(b8.out_chan) != k % C8 || b8.out_data !== 32'hC0DE0000 + (k % C8))
        $display("FAIL rr_sweep got=%b/%0d/%h exp=1/%0d step=%0d", b8.out_valid, b8.out_chan, b8.out_data, k % C8, k);
      else n_pass++;
    end
    b8.in_valid = '0;
  endtask

  task automatic test_rr_skip_wrap();
    int exp_seq [3] = '{5, 1, 5};
    do_reset();
    b8.rr_mode = 1'b1; b8.out_ready = 1'b1; b8.in_valid = 8'h02;
    advance8();
    b8.in_valid = 8'h22;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (b8.in_ready !== exp_ready8()) $display("FAIL rr_skip_ready got=%h exp=%h", b8.in_ready, exp_ready8()); else n_pass++;
      advance8();
      n_chk++; if (int'(b8.out_chan) != exp_seq[k] || b8.out_valid !== 1'b1)
        $display("FAIL rr_skip got=%b/%0d exp=1/%0d step=%0d", b8.out_valid, b8.out_chan, exp_seq[k], k);
      else n_pass++;
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++; if (b8.out_valid !== 1'b0) $display("FAIL rr_reset_valid got=%b exp=0", b8.out_valid); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    advance8();
    n_chk++; if (b8.out_chan !== 3'd1 || b8.out_valid !== 1'b1)
      $display("FAIL rr_after_reset got=%b/%0d exp=1/1", b8.out_valid, b8.out_chan);
    else n_pass++;
    b8.in_valid = '0; b8.rr_mode = 1'b0;
  endtask
`endif

  // Random traffic against the model. rr_mode is randomised as well, which
  // also covers rr_mode being ignored when the feature is absent.
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      b8.sel       = 3'($urandom_range(0, 7));
      b8.rr_mode   = 1'($urandom_range(0, 1));
      b8.in_valid  = 8'($urandom);
      b8.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < C8; i++) set_data8(i, $urandom);
      #1;
      n_chk++; if (b8.in_ready !== exp_ready8())
        $display("FAIL rand_ready got=%h exp=%h cyc=%0d", b8.in_ready, exp_ready8(), k);
      else n_pass++;
      advance8();
      n_chk++; if (b8.out_valid !== m_v || b8.out_data !== m_d || int'(b8.out_chan) != m_c)
        $display("FAIL rand_out got=%b/%h/%0d exp=%b/%h/%0d cyc=%0d",
                 b8.out_valid, b8.out_data, b8.out_chan, m_v, m_d, m_c, k);
      else n_pass++;
    end
    b8.in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_explicit();
    test_backpressure();
    test_out_of_range();
    test_async_reset();
`ifdef MUXN_RR_EN
    test_rr_sweep();
    test_rr_skip_wrap();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
